alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Multi-cycle 16-bit ALU for the tinylabcpu datapath, directly downstream of the control unit.
- Executes the operation selected by `alu_func` on operands presented by the datapath, whose B-operand mux is driven by `alu_in_sel`.
- Returns `alu_end`, which the control unit's state machine waits on before writeback.
- Single-cycle logic/arithmetic ops; iterative 16-step multiply and divide.

Parameters:
- WIDTH, 16, datapath width; the operation encodings below assume 16.
- ITER, 16, iteration count for MUL/DIV; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_start  input  1  one-cycle request; sampled only in IDLE.
- alu_func  input  4  operation code, latched on accept.
- op_a  input  WIDTH  operand A, latched on accept.
- op_b  input  WIDTH  operand B (post alu_in_sel mux), latched on accept.
- alu_out  output  WIDTH  primary result: sum/logic/shift/product low/quotient.
- alu_hi  output  WIDTH  product high half (MUL) or remainder (DIV); 0 for other ops.
- alu_end  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.
- flag_z  output  1  alu_out == 0.
- flag_n  output  1  alu_out[15].
- flag_c  output  1  carry/borrow/shifted-out bit (see below).
- flag_v  output  1  signed overflow (ADD/SUB only).
- flag_dz  output  1  divide by zero on last DIV.

Behaviour:
- Reset: state IDLE; alu_out, alu_hi, all flags, alu_end and busy = 0; iteration counter = 0.
- Opcodes:
  - 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by op_b[3:0]; 7 SHR logical A by op_b[3:0].
  - 8 MUL unsigned; 9 DIV unsigned; A PASS B; B PASS A.
  - C-F reserved: result 0, flags z=1 n=0 c=0 v=0, complete as single-cycle.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: alu_start=1 latches func/op_a/op_b.
    - Single-cycle op: result and flags registered, go to DONE.
    - Op 8: clear accumulator, go to MUL.
    - Op 9 with op_b != 0: go to DIV.
    - Op 9 with op_b == 0: go to DONE.
  - MUL: shift-add, one bit per cycle for ITER cycles; on the last step register results, go to DONE.
  - DIV: restoring division, one bit per cycle for ITER cycles; on the last step register results, go to DONE.
  - DONE: alu_end=1 for exactly one cycle, then IDLE.
- Latency, with alu_start high in cycle 0:
  - Single-cycle op: alu_end high in cycle 1.
  - MUL/DIV: alu_end high in cycle 17.
  - DIV by zero: alu_end high in cycle 1.
- alu_out, alu_hi and flags change only on the edge entering DONE; they hold until the next completion.
- No start is accepted in MUL, DIV or DONE; alu_start there is ignored, not queued. Minimum issue interval is 2 cycles.
- Flag rules:
  - ADD: c = carry out; v = (a15==b15) && (r15!=a15).
  - SUB: c = borrow (A<B unsigned); v = (a15!=b15) && (r15!=a15).
  - SHL: c = last bit shifted out; c=0 when amount=0.
  - SHR: c = last bit shifted out; c=0 when amount=0.
  - MUL: c = (alu_hi != 0).
  - All other ops: c=0, v=0.
  - flag_dz is updated on DIV only; it holds across non-DIV ops.
- DIV by zero: alu_out=16'hFFFF, alu_hi=op_a, flag_dz=1, z=0, n=1.
- Operands changing after accept have no effect on the result.
- rst in any state aborts the operation, returns to IDLE with reset values, and produces no alu_end.
- rst and alu_start high in the same cycle: reset wins, request dropped.

Test Plan:
- ADD 16'h7FFF + 16'h0001 -> alu_out=16'h8000, n=1, v=1, c=0, z=0, alu_end in cycle 1.
- SUB 16'h0003 - 16'h0005 -> alu_out=16'hFFFE, c=1, v=0, n=1.
- SHL 16'h8001 by 1 -> alu_out=16'h0002, c=1.
- MUL 16'h1234 * 16'h0100 -> alu_out=16'h3400, alu_hi=16'h0012, c=1, alu_end in cycle 17 only, busy high cycles 1-17.
- DIV 100/7 -> alu_out=16'h000E, alu_hi=16'h0002, dz=0, end in cycle 17.
- DIV 5/0 -> alu_out=16'hFFFF, alu_hi=16'h0005, dz=1, end in cycle 1.
- Start ADD at cycle 5 during MUL -> ignored; MUL result unchanged.
- rst at cycle 8 of MUL -> all outputs 0 next cycle, no alu_end.
- A new ADD after the reset completes normally.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bus between the tinylabcpu control unit/datapath and the ALU.
interface alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             alu_start;
    logic [3:0]       alu_func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_hi;
    logic             alu_end;
    logic             busy;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             flag_dz;

    // Requester side (control unit / datapath)
    modport master (
        output alu_start, alu_func, op_a, op_b,
        input  alu_out, alu_hi, alu_end, busy,
        input  flag_z, flag_n, flag_c, flag_v, flag_dz
    );

    // ALU side
    modport slave (
        input  alu_start, alu_func, op_a, op_b,
        output alu_out, alu_hi, alu_end, busy,
        output flag_z, flag_n, flag_c, flag_v, flag_dz
    );
endinterface

// File: rtl/alu_core.sv
// Multi-cycle 16-bit ALU: single-cycle logic/arith ops, iterative
// shift-add multiply and restoring divide. Results and flags are
// registered on the edge entering DONE and held until the next completion.
module alu_core #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 16
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_PSB  = 4'hA;
    localparam logic [3:0] OP_PSA  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;          // multiplicand
    logic [WIDTH-1:0] b_q, b_d;          // divisor
    logic [WIDTH-1:0] acc_hi, acc_hi_d;  // product high / partial remainder
    logic [WIDTH-1:0] acc_lo, acc_lo_d;  // multiplier->product low / dividend->quotient

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, dz_q, dz_d;
    logic             end_q, end_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   sh_ext;
    logic [3:0]       shamt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;

    assign shamt = bus.op_b[3:0];

    // Single-cycle operation result and carry/overflow from the live operands
    always_comb begin
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sum_ext = '0;
        sh_ext  = '0;
        case (bus.alu_func)
            OP_ADD: begin
                sum_ext = {1'b0, bus.op_a} + {1'b0, bus.op_b};
                sc_res  = sum_ext[WIDTH-1:0];
                sc_c    = sum_ext[WIDTH];
                sc_v    = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                          (sc_res[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, bus.op_a} - {1'b0, bus.op_b};
                sc_res  = sum_ext[WIDTH-1:0];
                sc_c    = sum_ext[WIDTH];
                sc_v    = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                          (sc_res[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_AND: sc_res = bus.op_a & bus.op_b;
            OP_OR:  sc_res = bus.op_a | bus.op_b;
            OP_XOR: sc_res = bus.op_a ^ bus.op_b;
            OP_NOT: sc_res = ~bus.op_a;
            OP_SHL: begin
                // extra top bit catches the last bit shifted out
                sh_ext = {1'b0, bus.op_a} << shamt;
                sc_res = sh_ext[WIDTH-1:0];
                sc_c   = sh_ext[WIDTH];
            end
            OP_SHR: begin
                // extra bottom bit catches the last bit shifted out
                sh_ext = {bus.op_a, 1'b0} >> shamt;
                sc_res = sh_ext[WIDTH:1];
                sc_c   = sh_ext[0];
            end
            OP_PSB: sc_res = bus.op_b;
            OP_PSA: sc_res = bus.op_a;
            default: sc_res = '0;
        endcase
    end

    // Next state and next values of every register
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi;
        acc_lo_d = acc_lo;
        out_d    = out_q;
        hi_d     = hi_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        dz_d     = dz_q;
        end_d    = 1'b0;

        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_sh  = {acc_hi, acc_lo[WIDTH-1]};
        div_tr  = div_sh - {1'b0, b_q};

        case (state)
            S_IDLE: begin
                if (bus.alu_start) begin
                    a_d   = bus.op_a;
                    b_d   = bus.op_b;
                    cnt_d = '0;
                    if (bus.alu_func == OP_MUL) begin
                        acc_hi_d = '0;
                        acc_lo_d = bus.op_b;
                        state_d  = S_MUL;
                    end else if (bus.alu_func == OP_DIV) begin
                        if (bus.op_b != '0) begin
                            acc_hi_d = '0;
                            acc_lo_d = bus.op_a;
                            state_d  = S_DIV;
                        end else begin
                            out_d   = '1;
                            hi_d    = bus.op_a;
                            z_d     = 1'b0;
                            n_d     = 1'b1;
                            c_d     = 1'b0;
                            v_d     = 1'b0;
                            dz_d    = 1'b1;
                            end_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        out_d   = sc_res;
                        hi_d    = '0;
                        z_d     = (sc_res == '0);
                        n_d     = sc_res[WIDTH-1];
                        c_d     = sc_c;
                        v_d     = sc_v;
                        end_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo[WIDTH-1:1]};
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(ITER - 1)) begin
                    out_d   = acc_lo_d;
                    hi_d    = acc_hi_d;
                    z_d     = (acc_lo_d == '0);
                    n_d     = acc_lo_d[WIDTH-1];
                    c_d     = (acc_hi_d != '0);
                    v_d     = 1'b0;
                    end_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (!div_tr[WIDTH]) begin
                    acc_hi_d = div_tr[WIDTH-1:0];
                    acc_lo_d = {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = div_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(ITER - 1)) begin
                    out_d   = acc_lo_d;
                    hi_d    = acc_hi_d;
                    z_d     = (acc_lo_d == '0);
                    n_d     = acc_lo_d[WIDTH-1];
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    dz_d    = 1'b0;
                    end_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            out_q  <= '0;
            hi_q   <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            dz_q   <= 1'b0;
            end_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_hi <= acc_hi_d;
            acc_lo <= acc_lo_d;
            out_q  <= out_d;
            hi_q   <= hi_d;
            z_q    <= z_d;
            n_q    <= n_d;
            c_q    <= c_d;
            v_q    <= v_d;
            dz_q   <= dz_d;
            end_q  <= end_d;
            busy_q <= busy_d;
        end
    end

    assign bus.alu_out = out_q;
    assign bus.alu_hi  = hi_q;
    assign bus.flag_z  = z_q;
    assign bus.flag_n  = n_q;
    assign bus.flag_c  = c_q;
    assign bus.flag_v  = v_q;
    assign bus.flag_dz = dz_q;
    assign bus.alu_end = end_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: vector table applied through a
// scoreboard queue, plus hand sequences for busy/ignore/reset corners.
module tb_alu_core;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic dz_m;

    alu_if #(.WIDTH(16)) bus();

    alu_core #(.WIDTH(16), .ITER(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic [15:0] hi;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } vec_t;

    typedef struct {
        vec_t v;
        logic dz;
        int   lat;
        int   start_cyc;
    } exp_t;

    exp_t q[$];
    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] o, input logic [15:0] h,
                                input logic z, input logic n, input logic c, input logic v);
        vec_t r;
        r.func = f; r.a = a; r.b = b; r.out = o; r.hi = h;
        r.z = z; r.n = n; r.c = c; r.v = v;
        return r;
    endfunction

    // Scoreboard: every alu_end pops one expected record
    always @(negedge clk) begin
        if (!rst && bus.alu_end) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_end: alu_end=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("alu_out", 32'(bus.alu_out), 32'(e.v.out));
                chk("alu_hi", 32'(bus.alu_hi), 32'(e.v.hi));
                chk("flags_znvc_dz", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_dz}),
                    32'({e.v.z, e.v.n, e.v.c, e.v.v, e.dz}));
                chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    task automatic start_op(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.alu_func  = v.func;
        bus.op_a      = v.a;
        bus.op_b      = v.b;
        bus.alu_start = 1'b1;
        if (v.func == 4'h9) dz_m = (v.b == 16'h0000);
        e.v         = v;
        e.dz        = dz_m;
        e.lat       = (v.func == 4'h8 || (v.func == 4'h9 && v.b != 16'h0000)) ? 17 : 1;
        e.start_cyc = cyc;
        q.push_back(e);
        @(negedge clk);
        bus.alu_start = 1'b0;
        bus.alu_func  = 4'($urandom);
        bus.op_a      = 16'($urandom);
        bus.op_b      = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL timeout: busy still high after %0d cycles", n);
        end
        chk("outstanding", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({bus.alu_out, bus.alu_hi}), 32'd0);
        chk({name, "_ctl"}, 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v,
                                 bus.flag_dz, bus.alu_end, bus.busy}), 32'd0);
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        dz_m   = 1'b0;
        rst    = 1'b1;
        bus.alu_start = 1'b0;
        bus.alu_func  = 4'h0;
        bus.op_a      = 16'h0000;
        bus.op_b      = 16'h0000;

        //             func   a         b         out       hi        z     n     c     v
        vecs.push_back(mk(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(4'h6, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h8, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h9, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h9, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h5, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h7, 16'h8001, 16'h0010, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h7, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h6, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'hA, 16'h1111, 16'h2222, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hB, 16'h1111, 16'h2222, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hC, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h8, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h9, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h9, 16'h0007, 16'h0010, 16'h0000, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;

        // Vector table through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i]);
            wait_idle();
        end

        // MUL with busy tracking; an ADD request in cycle 5 must be ignored
        start_op(mk(4'h8, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 1; k <= 17; k++) begin
            chk("busy_during_mul", 32'(bus.busy), 32'd1);
            if (k == 5) begin
                bus.alu_start = 1'b1;
                bus.alu_func  = 4'h0;
                bus.op_a      = 16'h0001;
                bus.op_b      = 16'h0001;
            end else begin
                bus.alu_start = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy_after_mul", 32'(bus.busy), 32'd0);
        wait_idle();

        // Reset in cycle 8 of a MUL aborts it with no completion
        start_op(mk(4'h8, 16'h00FF, 16'h00FF, 16'hFE01, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (7) @(negedge clk);
        rst = 1'b1;
        q.delete();
        dz_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("after_abort");
        repeat (20) @(negedge clk);
        chk("idle_after_abort", 32'(bus.busy), 32'd0);

        // New ADD after reset completes normally
        start_op(mk(4'h0, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_idle();

        // Reset and start together: request dropped
        @(negedge clk);
        rst           = 1'b1;
        bus.alu_start = 1'b1;
        bus.alu_func  = 4'h0;
        bus.op_a      = 16'h0101;
        bus.op_b      = 16'h0101;
        @(negedge clk);
        rst           = 1'b0;
        bus.alu_start = 1'b0;
        repeat (3) begin
            chk_all_zero("rst_with_start");
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
